memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have a single clock and a synchronous active-low reset; ports are clk and rst, and rst is sampled only at the posedge of clk.
REQ-002 SHALL have these upstream inputs from execute, all 1-bit unless stated: memEn, memWrt, regWrt, halt, err; regWrtSrc [2:0]; writeReg [2:0]; aluOut [15:0] (result/address); reg2Data [15:0] (store data); setVal [15:0]; nextPc [15:0]; instr [15:0].
REQ-003 SHALL have these data-memory ports: memAddr out 16; memWData out 16; memRd out 1; memWr out 1; memRData in 16; memDone in 1 (one-cycle completion pulse).
REQ-004 SHALL have these outputs to writeback, all registered: regWrtOut 1; regWrtSrcOut 3; writeRegOut 3; aluOutOut 16; memDataOut 16; setValOut 16; nextPcOut 16; instrOut 16; haltOut 1; errOut 1.
REQ-005 SHALL drive memStall out 1 to the hazard unit; memStall high means upstream registers hold.

Function
REQ-006 SHALL implement a state machine with states IDLE, BUSY, and ERR.
REQ-007 In IDLE with memEn=0, outputs SHALL register their inputs on the next edge (1-cycle latency); memRd, memWr, and memStall SHALL be 0.
REQ-008 In IDLE with memEn=1, the access SHALL issue combinationally in the same cycle: memAddr=aluOut, memWData=reg2Data, memWr=memWrt, memRd=~memWrt; memStall=1 unless memDone=1 in that cycle.
REQ-009 The state SHALL go IDLE->BUSY when memEn=1 and memDone=0; on entry the request fields SHALL be latched internally.
REQ-010 In BUSY, the latched address, data, and rd/wr SHALL be held stable on the memory ports, memStall=1, and upstream inputs SHALL be ignored.
REQ-011 On memDone=1 (in IDLE-issue or BUSY): memDataOut<=memRData for reads (unchanged for writes); all other outputs SHALL load the latched or current instruction fields; state->IDLE; memStall=0 in that cycle.
REQ-012 While stalled, regWrtOut and haltOut SHALL be 0 (a bubble); the writeback outputs SHALL update only on the completion edge.
REQ-013 SHALL keep a 4-bit timeout counter: cleared on issue, incremented each BUSY cycle without memDone; when it reaches 15, state->ERR.
REQ-014 In ERR: errOut=1 and haltOut=1 held; memRd=memWr=0; memStall=1; exit only by reset.
REQ-015 errOut SHALL be the registered value of err OR any internal error; haltOut SHALL be registered halt, asserted only after any outstanding access completes.
REQ-016 A memDone pulse arriving in IDLE with memEn=0 SHALL be ignored.
REQ-017 Back-to-back accesses: the cycle after completion, state=IDLE, and a new memEn SHALL issue immediately (no dead cycle).

Reset
REQ-018 With rst=0 at posedge: state=IDLE, counter=0, and all registered outputs=0; combinational memRd, memWr, and memStall SHALL be 0 during reset.
REQ-019 Reset in BUSY or ERR SHALL abandon the access; a late memDone after reset SHALL be ignored per REQ-016.

Configuration
REQ-020 Macro MEM_ALIGN_CHECK_EN: when defined, memEn=1 with aluOut[0]=1 SHALL suppress memRd/memWr, go to ERR the next edge, and set errOut=1; when undefined, no check is made and the address passes unmodified.

Verification
REQ-021 ALU op, memEn=0, aluOut=0x1234, regWrt=1, writeReg=3 -> next edge aluOutOut=0x1234, regWrtOut=1, writeRegOut=3, memStall=0.
REQ-022 Load aluOut=0x0040, memDone after 3 cycles with memRData=0xBEEF -> memStall high 3 cycles, memAddr held 0x0040, then memDataOut=0xBEEF, regWrtOut=1.
REQ-023 Store aluOut=0x0010, reg2Data=0xA5A5, memDone same cycle -> memWr=1 one cycle, memStall=0, output valid next edge, no BUSY entry.
REQ-024 Load, memDone never asserted -> after 15 BUSY cycles state=ERR, errOut=1, haltOut=1, memRd=0.
REQ-025 Reset asserted mid-BUSY, then memDone pulse -> all outputs 0, state IDLE, pulse ignored.
REQ-026 With MEM_ALIGN_CHECK_EN, load at 0x0041 -> no memRd, errOut=1 next edge; without the macro, memRd=1 and memAddr=0x0041.

Source files
------------

// File: rtl/memory_stage.sv
// Memory stage: issues data-memory accesses from execute results and registers the writeback bundle.
// Latency: 1 cycle for non-memory ops and same-cycle completions; stalls until memDone otherwise.
// Backpressure: memStall holds upstream while an access is outstanding or after a fatal timeout/error.
// Build option: define MEM_ALIGN_CHECK_EN to trap odd (misaligned) memory addresses into the ERR state.

module memory_stage (
    input  logic        clk,
    input  logic        rst,           // synchronous, active-low
    // from execute
    input  logic        memEn,
    input  logic        memWrt,
    input  logic        regWrt,
    input  logic        halt,
    input  logic        err,
    input  logic [2:0]  regWrtSrc,
    input  logic [2:0]  writeReg,
    input  logic [15:0] aluOut,
    input  logic [15:0] reg2Data,
    input  logic [15:0] setVal,
    input  logic [15:0] nextPc,
    input  logic [15:0] instr,
    // data memory
    output logic [15:0] memAddr,
    output logic [15:0] memWData,
    output logic        memRd,
    output logic        memWr,
    input  logic [15:0] memRData,
    input  logic        memDone,
    // to writeback
    output logic        regWrtOut,
    output logic [2:0]  regWrtSrcOut,
    output logic [2:0]  writeRegOut,
    output logic [15:0] aluOutOut,
    output logic [15:0] memDataOut,
    output logic [15:0] setValOut,
    output logic [15:0] nextPcOut,
    output logic [15:0] instrOut,
    output logic        haltOut,
    output logic        errOut,
    // to hazard unit
    output logic        memStall
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    // Instruction fields that travel to writeback unchanged.
    typedef struct packed {
        logic        regWrt;
        logic [2:0]  regWrtSrc;
        logic [2:0]  writeReg;
        logic [15:0] aluOut;
        logic [15:0] setVal;
        logic [15:0] nextPc;
        logic [15:0] instr;
        logic        halt;
        logic        err;
    } fld_t;

    // The memory request itself, held stable while BUSY.
    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        wr;
    } req_t;

    // Number of unanswered BUSY cycles tolerated is 15; the 15th miss moves to ERR.
    localparam logic [3:0] TIMEOUT_LAST = 4'd14;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_t        req_q, req_d;
    fld_t        fld_q, fld_d;
    fld_t        wb_q, wb_d;
    logic [15:0] mdata_q, mdata_d;

    fld_t        cur_fld;
    req_t        cur_req;
    logic        misalign;

    assign cur_fld = '{regWrt:    regWrt,
                       regWrtSrc: regWrtSrc,
                       writeReg:  writeReg,
                       aluOut:    aluOut,
                       setVal:    setVal,
                       nextPc:    nextPc,
                       instr:     instr,
                       halt:      halt,
                       err:       err};

    assign cur_req = '{addr: aluOut, wdata: reg2Data, wr: memWrt};

`ifdef MEM_ALIGN_CHECK_EN
    // Word accesses must be even; an odd address is a fatal fault.
    assign misalign = memEn & aluOut[0];
`else
    assign misalign = 1'b0;
`endif

    // State register plus the latched request/fields, counter and writeback registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            fld_q   <= '0;
            wb_q    <= '0;
            mdata_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            fld_q   <= fld_d;
            wb_q    <= wb_d;
            mdata_q <= mdata_d;
        end
    end

    // Next-state: wait in BUSY for memDone, fall into ERR on timeout or misalignment.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (memEn) begin
                    if (misalign) begin
                        state_d = ST_ERR;
                    end else if (!memDone) begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (memDone) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_ERR;
                end
            end
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory-port and stall outputs; all strobes are forced low while reset is asserted.
    always_comb begin
        memRd    = 1'b0;
        memWr    = 1'b0;
        memStall = 1'b0;
        memAddr  = aluOut;
        memWData = reg2Data;
        if (rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (memEn && !misalign) begin
                        memRd    = ~memWrt;
                        memWr    = memWrt;
                        memStall = ~memDone;
                    end else if (memEn) begin
                        memStall = 1'b1;
                    end
                end
                ST_BUSY: begin
                    memAddr  = req_q.addr;
                    memWData = req_q.wdata;
                    memRd    = ~req_q.wr;
                    memWr    = req_q.wr;
                    memStall = ~memDone;
                end
                ST_ERR: begin
                    memAddr  = req_q.addr;
                    memWData = req_q.wdata;
                    memStall = 1'b1;
                end
                default: begin
                    memStall = 1'b0;
                end
            endcase
        end
    end

    // Datapath: latch on issue, count BUSY misses, and load the writeback bundle on completion.
    always_comb begin
        cnt_d   = cnt_q;
        req_d   = req_q;
        fld_d   = fld_q;
        wb_d    = wb_q;
        mdata_d = mdata_q;
        case (state_q)
            ST_IDLE: begin
                if (!memEn) begin
                    // Plain ALU op (a stray memDone here is meaningless and ignored).
                    wb_d = cur_fld;
                end else if (misalign) begin
                    wb_d.regWrt = 1'b0;
                    wb_d.halt   = 1'b1;
                    wb_d.err    = 1'b1;
                end else if (memDone) begin
                    // Same-cycle completion: never enters BUSY.
                    wb_d = cur_fld;
                    if (!memWrt) begin
                        mdata_d = memRData;
                    end
                end else begin
                    req_d       = cur_req;
                    fld_d       = cur_fld;
                    cnt_d       = 4'd0;
                    wb_d.regWrt = 1'b0;
                    wb_d.halt   = 1'b0;
                end
            end
            ST_BUSY: begin
                if (memDone) begin
                    wb_d = fld_q;
                    if (!req_q.wr) begin
                        mdata_d = memRData;
                    end
                end else begin
                    cnt_d       = cnt_q + 4'd1;
                    wb_d.regWrt = 1'b0;
                    wb_d.halt   = 1'b0;
                    if (cnt_q == TIMEOUT_LAST) begin
                        wb_d.halt = 1'b1;
                        wb_d.err  = 1'b1;
                    end
                end
            end
            ST_ERR: begin
                wb_d.regWrt = 1'b0;
                wb_d.halt   = 1'b1;
                wb_d.err    = 1'b1;
            end
            default: begin
                wb_d = wb_q;
            end
        endcase
    end

    assign regWrtOut    = wb_q.regWrt;
    assign regWrtSrcOut = wb_q.regWrtSrc;
    assign writeRegOut  = wb_q.writeReg;
    assign aluOutOut    = wb_q.aluOut;
    assign memDataOut   = mdata_q;
    assign setValOut    = wb_q.setVal;
    assign nextPcOut    = wb_q.nextPc;
    assign instrOut     = wb_q.instr;
    assign haltOut      = wb_q.halt;
    assign errOut       = wb_q.err;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios followed by random traffic.
// Outputs are compared every cycle against a transaction-level reference model.
// Combinational ports are sampled at negedge, registered ports 1 ns after posedge.

module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        memEn, memWrt, regWrt, halt, err;
    logic [2:0]  regWrtSrc, writeReg;
    logic [15:0] aluOut, reg2Data, setVal, nextPc, instr;
    logic [15:0] memAddr, memWData, memRData;
    logic        memRd, memWr, memDone;
    logic        regWrtOut, haltOut, errOut, memStall;
    logic [2:0]  regWrtSrcOut, writeRegOut;
    logic [15:0] aluOutOut, memDataOut, setValOut, nextPcOut, instrOut;

    int checks     = 0;
    int failures   = 0;
    int stall_seen = 0;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk(clk), .rst(rst),
        .memEn(memEn), .memWrt(memWrt), .regWrt(regWrt), .halt(halt), .err(err),
        .regWrtSrc(regWrtSrc), .writeReg(writeReg), .aluOut(aluOut), .reg2Data(reg2Data),
        .setVal(setVal), .nextPc(nextPc), .instr(instr),
        .memAddr(memAddr), .memWData(memWData), .memRd(memRd), .memWr(memWr),
        .memRData(memRData), .memDone(memDone),
        .regWrtOut(regWrtOut), .regWrtSrcOut(regWrtSrcOut), .writeRegOut(writeRegOut),
        .aluOutOut(aluOutOut), .memDataOut(memDataOut), .setValOut(setValOut),
        .nextPcOut(nextPcOut), .instrOut(instrOut), .haltOut(haltOut), .errOut(errOut),
        .memStall(memStall)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        regWrt;
        logic [2:0]  src;
        logic [2:0]  wreg;
        logic [15:0] alu;
        logic [15:0] r2;
        logic [15:0] setv;
        logic [15:0] npc;
        logic [15:0] ins;
        logic        halt;
        logic        err;
        logic        wrt;
    } txn_t;

    txn_t pend;            // the outstanding access, if any
    bit   m_busy = 0;      // an access is waiting for memDone
    bit   m_dead = 0;      // fatal error: only reset recovers
    int   m_wait = 0;      // unanswered cycles of the outstanding access

    logic        e_regWrt, e_halt, e_err;
    logic [2:0]  e_src, e_wreg;
    logic [15:0] e_alu, e_mdata, e_setv, e_npc, e_ins;

    function automatic txn_t cur_txn();
        txn_t t;
        t.regWrt = regWrt; t.src = regWrtSrc; t.wreg = writeReg; t.alu = aluOut;
        t.r2 = reg2Data; t.setv = setVal; t.npc = nextPc; t.ins = instr;
        t.halt = halt; t.err = err; t.wrt = memWrt;
        return t;
    endfunction

    function automatic bit misaligned();
`ifdef MEM_ALIGN_CHECK_EN
        return aluOut[0];
`else
        return 1'b0;
`endif
    endfunction

    task automatic retire(input txn_t t);
        e_regWrt = t.regWrt; e_src = t.src; e_wreg = t.wreg; e_alu = t.alu;
        e_setv = t.setv; e_npc = t.npc; e_ins = t.ins; e_halt = t.halt; e_err = t.err;
        if (!t.wrt) e_mdata = memRData;
    endtask

    task automatic bubble();
        e_regWrt = 1'b0;
        e_halt   = 1'b0;
    endtask

    task automatic go_dead();
        m_dead = 1; m_busy = 0;
        e_regWrt = 1'b0; e_halt = 1'b1; e_err = 1'b1;
    endtask

    // What the writeback registers should hold after this clock edge.
    task automatic model_edge();
        txn_t c;
        c = cur_txn();
        if (!rst) begin
            m_busy = 0; m_dead = 0; m_wait = 0;
            e_regWrt = 0; e_halt = 0; e_err = 0; e_src = 0; e_wreg = 0;
            e_alu = 0; e_mdata = 0; e_setv = 0; e_npc = 0; e_ins = 0;
        end else if (m_dead) begin
            go_dead();
        end else if (m_busy) begin
            if (memDone) begin
                retire(pend);
                m_busy = 0;
            end else begin
                m_wait++;
                bubble();
                if (m_wait >= 15) go_dead();
            end
        end else if (memEn) begin
            if (misaligned()) go_dead();
            else if (memDone) retire(c);
            else begin
                pend = c; m_busy = 1; m_wait = 0;
                bubble();
            end
        end else begin
            c.wrt = 1'b1;           // no memory read: memDataOut keeps its value
            retire(c);
        end
    endtask

    // What the memory port and stall should show in the current cycle.
    task automatic model_comb(output logic rd, output logic wr, output logic st,
                              output logic acc, output logic [15:0] a, output logic [15:0] d);
        rd = 0; wr = 0; st = 0; acc = 0; a = 0; d = 0;
        if (rst) begin
            if (m_dead) begin
                st = 1;
            end else if (m_busy) begin
                acc = 1; rd = !pend.wrt; wr = pend.wrt; a = pend.alu; d = pend.r2; st = !memDone;
            end else if (memEn) begin
                if (misaligned()) st = 1;
                else begin
                    acc = 1; rd = !memWrt; wr = memWrt; a = aluOut; d = reg2Data; st = !memDone;
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outs();
        chk("regWrtOut", regWrtOut, e_regWrt);
        chk("regWrtSrcOut", regWrtSrcOut, e_src);
        chk("writeRegOut", writeRegOut, e_wreg);
        chk("aluOutOut", aluOutOut, e_alu);
        chk("memDataOut", memDataOut, e_mdata);
        chk("setValOut", setValOut, e_setv);
        chk("nextPcOut", nextPcOut, e_npc);
        chk("instrOut", instrOut, e_ins);
        chk("haltOut", haltOut, e_halt);
        chk("errOut", errOut, e_err);
    endtask

    task automatic cycle();
        logic rd, wr, st, acc;
        logic [15:0] a, d;
        @(negedge clk);
        model_comb(rd, wr, st, acc, a, d);
        chk("memRd", memRd, rd);
        chk("memWr", memWr, wr);
        chk("memStall", memStall, st);
        if (acc) begin
            chk("memAddr", memAddr, a);
            chk("memWData", memWData, d);
        end
        if (memStall === 1'b1) stall_seen++;
        @(posedge clk);
        model_edge();
        #1;
        check_outs();
    endtask

    task automatic drive(input logic en, input logic wrt, input logic done,
                         input logic [15:0] alu, input logic [15:0] r2,
                         input logic rw, input logic [2:0] wreg);
        memEn = en; memWrt = wrt; memDone = done; aluOut = alu; reg2Data = r2;
        regWrt = rw; writeReg = wreg;
    endtask

    task automatic randomize_inputs();
        memEn = ($urandom_range(0, 1) == 1);
        memWrt = ($urandom_range(0, 1) == 1);
        memDone = ($urandom_range(0, 99) < 35);
        regWrt = $urandom_range(0, 1); halt = ($urandom_range(0, 15) == 0);
        err = ($urandom_range(0, 15) == 0);
        regWrtSrc = 3'($urandom); writeReg = 3'($urandom);
        aluOut = 16'($urandom); reg2Data = 16'($urandom); setVal = 16'($urandom);
        nextPc = 16'($urandom); instr = 16'($urandom); memRData = 16'($urandom);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 0; memEn = 0; memWrt = 0; regWrt = 0; halt = 0; err = 0;
        regWrtSrc = 0; writeReg = 0; aluOut = 0; reg2Data = 0; setVal = 0;
        nextPc = 0; instr = 0; memRData = 0; memDone = 0;
        e_regWrt = 0; e_halt = 0; e_err = 0; e_src = 0; e_wreg = 0;
        e_alu = 0; e_mdata = 0; e_setv = 0; e_npc = 0; e_ins = 0;
        pend = '0;

        // Reset: outputs zero, strobes gated even with a request pending.
        cycle();
        memEn = 1; memDone = 0; aluOut = 16'h0022;
        cycle();
        chk("reset_stall", memStall, 1'b0);
        chk("reset_aluOutOut", aluOutOut, 16'h0000);

        // Plain ALU op.
        rst = 1;
        drive(1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 1'b1, 3'd3);
        setVal = 16'h0101; nextPc = 16'h0202; instr = 16'h0303;
        cycle();
        chk("alu_aluOutOut", aluOutOut, 16'h1234);
        chk("alu_regWrtOut", regWrtOut, 1'b1);
        chk("alu_writeRegOut", writeRegOut, 3'd3);

        // Load answered after three stalled cycles; upstream changes are ignored meanwhile.
        stall_seen = 0;
        memRData = 16'h0000;
        drive(1'b1, 1'b0, 1'b0, 16'h0040, 16'h1111, 1'b1, 3'd5);
        cycle();
        chk("load_bubble_regWrtOut", regWrtOut, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h2222, 1'b0, 3'd1);
        cycle();
        cycle();
        memDone = 1; memRData = 16'hBEEF;
        cycle();
        chk("load_stall_cycles", stall_seen, 3);
        chk("load_memDataOut", memDataOut, 16'hBEEF);
        chk("load_regWrtOut", regWrtOut, 1'b1);
        chk("load_aluOutOut", aluOutOut, 16'h0040);

        // Store completing in its own issue cycle.
        stall_seen = 0;
        drive(1'b1, 1'b1, 1'b1, 16'h0010, 16'hA5A5, 1'b0, 3'd0);
        memRData = 16'h5555;
        cycle();
        chk("store_no_stall", stall_seen, 0);
        chk("store_memDataOut_kept", memDataOut, 16'hBEEF);

        // Stray memDone with no request, then back-to-back loads.
        drive(1'b0, 1'b0, 1'b1, 16'h0777, 16'h0000, 1'b1, 3'd2);
        cycle();
        drive(1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 1'b1, 3'd4);
        cycle();
        memDone = 1; memRData = 16'h1357;
        cycle();
        drive(1'b1, 1'b0, 1'b1, 16'h0200, 16'h0000, 1'b1, 3'd6);
        memRData = 16'h2468;
        cycle();
        chk("b2b_memDataOut", memDataOut, 16'h2468);

        // Load that never completes: timeout to ERR.
        drive(1'b1, 1'b0, 1'b0, 16'h0300, 16'h0000, 1'b1, 3'd7);
        cycle();
        memEn = 0;
        repeat (17) cycle();
        chk("timeout_errOut", errOut, 1'b1);
        chk("timeout_haltOut", haltOut, 1'b1);

        // Reset mid-BUSY, then a late memDone.
        rst = 0; cycle();
        rst = 1;
        drive(1'b1, 1'b0, 1'b0, 16'h0400, 16'h0000, 1'b1, 3'd1);
        cycle();
        memEn = 0; cycle();
        rst = 0; cycle();
        rst = 1;
        drive(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 3'd0);
        halt = 0; err = 0; setVal = 0; nextPc = 0; instr = 0; regWrtSrc = 0;
        memRData = 16'hDEAD;
        cycle();
        chk("late_done_memDataOut", memDataOut, 16'h0000);
        chk("late_done_errOut", errOut, 1'b0);

        // Odd address load.
        drive(1'b1, 1'b0, 1'b0, 16'h0041, 16'h0000, 1'b1, 3'd2);
        cycle();
        memDone = 1; memRData = 16'h0F0F;
        cycle();
        rst = 0; memDone = 0; cycle();
        rst = 1;

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            randomize_inputs();
            if (m_dead && $urandom_range(0, 3) == 0) rst = 0;
            else rst = ($urandom_range(0, 99) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
